// File: rtl/fwd_scoreboard_if.sv
// Issue/forwarding bundle between decode and the forwarding scoreboard.
// Decode side is the master, scoreboard is the slave.
interface fwd_scoreboard_if #(
  parameter int DATA_W = 64,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                    hold;
  logic                    flush;
  logic                    iss_valid;
  logic                    iss_we;
  logic                    iss_load;
  logic [4:0]              iss_rd;
  logic [NSRC*5-1:0]       src_addr;
  logic [NSRC-1:0]         src_used;
  logic [NSRC*DATA_W-1:0]  rf_data;
  logic [DEPTH*DATA_W-1:0] stg_data;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic [NSRC*DATA_W-1:0]  fwd_data;
  logic                    stall;

  modport master (
    output hold, flush, iss_valid, iss_we, iss_load, iss_rd,
    output src_addr, src_used, rf_data, stg_data,
    input  fwd_sel, fwd_data, stall
  );

  modport slave (
    input  hold, flush, iss_valid, iss_we, iss_load, iss_rd,
    input  src_addr, src_used, rf_data, stg_data,
    output fwd_sel, fwd_data, stall
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard with load-use stall detection.
// Define FWD_STALL_CNT_EN to add the saturating stall_cnt port.
module fwd_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef FWD_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  fwd_scoreboard_if.slave   bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam logic [4:0] ZR = 5'(ZERO_REG);

  typedef struct packed {
    logic       v;
    logic       we;
    logic       load;
    logic [4:0] rd;
  } ent_t;

  ent_t ent_q [DEPTH];
  ent_t ent_new;
  ent_t ent_sh;
  logic issue;

  assign issue = bus.iss_valid & ~bus.stall & ~bus.flush;

  always_comb begin
    ent_new = '0;
    if (issue) begin
      ent_new.v    = 1'b1;
      ent_new.we   = bus.iss_we;
      ent_new.load = bus.iss_load;
      ent_new.rd   = bus.iss_rd;
    end
  end

  // A flushed entry 0 still ages into entry 1, just invalidated
  always_comb begin
    ent_sh = ent_q[0];
    if (bus.flush) ent_sh.v = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++)
        ent_q[k] <= '0;
    end else if (bus.hold) begin
      if (bus.flush) ent_q[0].v <= 1'b0;
    end else begin
      ent_q[0] <= ent_new;
      ent_q[1] <= ent_sh;
      for (int k = 2; k < DEPTH; k++)
        ent_q[k] <= ent_q[k-1];
    end
  end

  logic              haz    [NSRC];
  logic [SEL_W-1:0]  sel_a  [NSRC];
  logic [DATA_W-1:0] data_a [NSRC];

  for (genvar s = 0; s < NSRC; s++) begin : g_port
    logic [4:0]       a;
    logic             used;
    logic             hit;
    logic             fwd;
    logic [SEL_W-1:0] idx;

    assign a    = bus.src_addr[s*5 +: 5];
    assign used = bus.src_used[s];

    // Scan oldest to youngest so the youngest match wins
    always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (used && a != ZR && ent_q[k].v &&
            ent_q[k].we && ent_q[k].rd == a) begin
          hit = 1'b1;
          idx = SEL_W'(k);
        end
      end
    end

    assign haz[s]    = hit & (idx == '0) & ent_q[0].load;
    assign fwd       = hit & ~haz[s];
    assign sel_a[s]  = fwd ? idx + SEL_W'(1) : '0;
    assign data_a[s] = fwd
      ? bus.stg_data[int'(idx)*DATA_W +: DATA_W]
      : bus.rf_data[s*DATA_W +: DATA_W];
  end

  logic any_haz;

  always_comb begin
    any_haz      = 1'b0;
    bus.fwd_sel  = '0;
    bus.fwd_data = '0;
    for (int s = 0; s < NSRC; s++) begin
      bus.fwd_sel[s*SEL_W +: SEL_W]   = sel_a[s];
      bus.fwd_data[s*DATA_W +: DATA_W] = data_a[s];
      any_haz = any_haz | haz[s];
    end
  end

  assign bus.stall = bus.iss_valid & ~bus.flush & any_haz;

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (bus.stall && !bus.hold && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
